// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the multiply/divide unit: op-code
//               values, FSM state encoding, op-class decode helpers and the
//               divide-by-zero / signed-overflow result constants.
//               Optional feature macro: MDU_MADD_EN (enables ops 6-9).
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [3:0] C_OP_MULT  = 4'd0;
    localparam logic [3:0] C_OP_MULTU = 4'd1;
    localparam logic [3:0] C_OP_DIV   = 4'd2;
    localparam logic [3:0] C_OP_DIVU  = 4'd3;
    localparam logic [3:0] C_OP_MTHI  = 4'd4;
    localparam logic [3:0] C_OP_MTLO  = 4'd5;
    localparam logic [3:0] C_OP_MADD  = 4'd6;
    localparam logic [3:0] C_OP_MADDU = 4'd7;
    localparam logic [3:0] C_OP_MSUB  = 4'd8;
    localparam logic [3:0] C_OP_MSUBU = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Result constants, sized for the widest supported WIDTH and sliced
    // down by the user.
    localparam int              C_MAX_WIDTH = 64;
    localparam logic [C_MAX_WIDTH-1:0] C_DIV0_QUOT = '1;  // quotient on B == 0
    localparam logic [C_MAX_WIDTH-1:0] C_OVF_REM   = '0;  // remainder on MIN / -1

    // Ops that take MULT_LAT busy cycles.
    function automatic logic is_mult_class(input logic [3:0] op);
        logic r;
        r = (op == C_OP_MULT) || (op == C_OP_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == C_OP_MADD) || (op == C_OP_MADDU) ||
                 (op == C_OP_MSUB) || (op == C_OP_MSUBU);
`endif
        return r;
    endfunction

    // Ops that take DIV_LAT busy cycles.
    function automatic logic is_div_class(input logic [3:0] op);
        return (op == C_OP_DIV) || (op == C_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// Module      : mdu_calc
// Description : Purely combinational result generator for the MDU. Produces
//               the 2*WIDTH {HI,LO} value for multiply, divide and (when
//               MDU_MADD_EN is defined) multiply-accumulate ops.
// Ports       : i_op     - operation code
//               i_hilo   - current {HI,LO} (only with MDU_MADD_EN)
//               i_a/i_b  - operands rs / rt
//               o_result - {HI,LO} result to be held as pending
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         i_op,
`ifdef MDU_MADD_EN
    input  logic [2*WIDTH-1:0] i_hilo,
`endif
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_result
);

    localparam int DW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             w_signed_op;
    logic [DW-1:0]    w_a_ext;
    logic [DW-1:0]    w_b_ext;
    logic [DW-1:0]    w_prod;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_b_div;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_signed_op = (i_op == C_OP_MULT) || (i_op == C_OP_DIV) ||
                         (i_op == C_OP_MADD) || (i_op == C_OP_MSUB);

    // Extending to 2*WIDTH before multiplying makes the truncated product
    // exact for both signed and unsigned operands.
    assign w_a_ext = w_signed_op ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
    assign w_b_ext = w_signed_op ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed division on magnitudes; quotient sign is the XOR of operand
    // signs, remainder takes the dividend's sign.
    assign w_a_neg = w_signed_op & i_a[WIDTH-1];
    assign w_b_neg = w_signed_op & i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;
    // Keeps the divider input non-zero; the B == 0 case is overridden below.
    assign w_b_div = (w_b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
    assign w_q_mag = w_a_mag / w_b_div;
    assign w_r_mag = w_a_mag % w_b_div;
    assign w_quot  = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
    assign w_rem   = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;

    always_comb begin
        o_result = '0;
        case (i_op)
            C_OP_MULT, C_OP_MULTU: o_result = w_prod;
            C_OP_DIV, C_OP_DIVU: begin
                if (i_b == '0) begin
                    o_result = {i_a, C_DIV0_QUOT[WIDTH-1:0]};
                end else if (w_signed_op && (i_a == C_MIN) && (i_b == '1)) begin
                    o_result = {C_OVF_REM[WIDTH-1:0], C_MIN};
                end else begin
                    o_result = {w_rem, w_quot};
                end
            end
`ifdef MDU_MADD_EN
            C_OP_MADD, C_OP_MADDU: o_result = i_hilo + w_prod;
            C_OP_MSUB, C_OP_MSUBU: o_result = i_hilo - w_prod;
`endif
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Multi-cycle multiply/divide unit with architectural HI/LO.
//               Accepts one op per start pulse while idle, holds busy for
//               MULT_LAT or DIV_LAT cycles, then commits {HI,LO} and pulses
//               done for one cycle. MTHI/MTLO write in zero busy cycles.
//               Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU).
// Ports       : clk, reset_n (async, active low)
//               start, op, A, B  - issue request and operands
//               busy, done       - in-flight flag, commit pulse
//               hi, lo           - HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [2*WIDTH-1:0]   r_pending;
    logic [2*WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 w_load_pending;
    logic                 w_commit;
    logic                 w_wr_hi;
    logic                 w_wr_lo;

    mdu_calc #(
        .WIDTH    (WIDTH)
    ) u_calc (
        .i_op     (op),
`ifdef MDU_MADD_EN
        .i_hilo   ({r_hi, r_lo}),
`endif
        .i_a      (A),
        .i_b      (B),
        .o_result (w_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and datapath enables. start is only looked at in IDLE, so
    // a request during BUSY has no effect at all.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_load_pending = 1'b0;
        w_commit       = 1'b0;
        w_wr_hi        = 1'b0;
        w_wr_lo        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (is_mult_class(op)) begin
                        w_load_pending = 1'b1;
                        w_cnt_next     = C_MULT_LOAD;
                        w_state_next   = ST_BUSY;
                    end else if (is_div_class(op)) begin
                        w_load_pending = 1'b1;
                        w_cnt_next     = C_DIV_LOAD;
                        w_state_next   = ST_BUSY;
                    end else if (op == C_OP_MTHI) begin
                        w_wr_hi = 1'b1;
                    end else if (op == C_OP_MTLO) begin
                        w_wr_lo = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_commit     = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_pending <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_done <= w_commit;
            if (w_load_pending) begin
                r_pending <= w_result;
            end
            if (w_commit) begin
                {r_hi, r_lo} <= r_pending;
            end else begin
                if (w_wr_hi) begin
                    r_hi <= A;
                end
                if (w_wr_lo) begin
                    r_lo <= A;
                end
            end
        end
    end

    assign busy = (r_state == ST_BUSY);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/mdu.md
# mdu

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, the sequential companion to the single-cycle ALU in the EX stage. It accepts one operation per start pulse, holds busy for a configurable latency so the hazard unit can stall MDU-dependent instructions, then commits the result to HI/LO. HI/LO are always visible combinationally for mfhi/mflo forwarding.

## Interface
- WIDTH, 32, operand and HI/LO width
- MULT_LAT, 5, busy cycles for multiply-class ops (≥1)
- DIV_LAT, 10, busy cycles for divide-class ops (≥1)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  issue request, sampled on rising clk
- op  in  4  operation code (see Operation)
- A  in  WIDTH  operand rs
- B  in  WIDTH  operand rt
- busy  out  1  operation in flight; start ignored while high
- done  out  1  one-cycle pulse after commit
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; any other code is a no-op (no busy, no write).
- States: IDLE, BUSY. Counter cnt, width ceil(log2(max(MULT_LAT, DIV_LAT)))+1.
- IDLE + start + MTHI/MTLO: HI or LO := A on that edge; busy stays 0; done not pulsed.
- IDLE + start + mult/div class: operands and op captured, result computed into pending registers; cnt := LAT−1; go to BUSY.
- BUSY: cnt decrements each edge; on the edge where cnt == 0, {HI,LO} := pending, state := IDLE, done := 1 for the following cycle.
- start while BUSY: ignored, no side effects. The controller stalls instead.
- MULT/MULTU: {HI,LO} := signed/unsigned 2·WIDTH product.
- DIV/DIVU: LO := quotient truncated toward zero, HI := remainder carrying the dividend's sign.
- Divide by zero: LO := all ones, HI := A. Signed overflow (A = MIN, B = −1): LO := MIN, HI := 0.
- MADD/MSUB: {HI,LO} := {HI,LO} ± product, modulo 2^(2·WIDTH), using HI/LO as captured at issue.

## Timing
- Reset (async, reset_n low): state IDLE, cnt 0, busy 0, done 0, hi 0, lo 0, pending cleared. Reset asserted mid-operation aborts it; HI/LO read 0.
- Start sampled at edge k, multiply: busy high in cycles k+1 … k+MULT_LAT. New HI/LO visible after edge k+MULT_LAT, the same edge on which busy falls. done is high in cycle k+MULT_LAT+1 only. Divide is identical with DIV_LAT.
- LAT = 1: busy is high for exactly one cycle.
- MTHI/MTLO: zero busy, result visible after the issue edge.
- A back-to-back start in the first IDLE cycle after commit is accepted. There is no bubble.

## Configuration
- MDU_MADD_EN defined: ops 6–9 are implemented as above.
- Not defined: ops 6–9 decode as no-op, and the accumulate adder and HI/LO feedback path are not synthesised.

## Structure
- Package mdu_pkg holds the op-code localparams, the state encoding (IDLE, BUSY), and the div-by-zero and overflow constants.
- One sub-module, mdu_calc, is purely combinational. It takes op, A, B and {HI,LO} and produces the 2·WIDTH pending result. The mdu top holds the FSM, counter, pending, HI and LO registers.

## Test plan
- MULT A=0xFFFFFFFE (−2), B=3 → busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, and done pulses once.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=−7, B=2 → after 10 busy cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIV A=5, B=0 → LO=0xFFFFFFFF, HI=5. DIV A=0x80000000, B=−1 → LO=0x80000000, HI=0.
- Start DIVU mid-multiply (cycle 3 of 5) → ignored; MULT result commits at the normal time, and no extra busy follows.
- MTHI 0x12345678 then MTLO 0x9 on consecutive cycles → busy stays 0, and hi/lo update one edge after each issue. With MDU_MADD_EN, a following MADDU A=2, B=3 gives LO=0xF and HI=0x12345678.
- Assert reset_n low during cycle 2 of a DIV → busy=0, done=0, hi=lo=0 immediately. After release, the next MULT completes normally.
